// File: rtl/cache_sim_pkg.sv
// Shared command codes, scheduler states and the buffered command bundle
// for the cache trace command scheduler.
package cache_sim_pkg;

    localparam logic [3:0] CMD_READ   = 4'd0;
    localparam logic [3:0] CMD_WRITE  = 4'd1;
    localparam logic [3:0] CMD_IFETCH = 4'd2;
    localparam logic [3:0] CMD_INVAL  = 4'd3;
    localparam logic [3:0] CMD_SNOOP  = 4'd4;
    localparam logic [3:0] CMD_CLEAR  = 4'd8;
    localparam logic [3:0] CMD_PRINT  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SWEEP,
        S_FINAL,
        S_DONE
    } sched_state_e;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] addr;
    } cmd_t;

    function automatic logic is_access(logic [3:0] c);
        return c <= CMD_SNOOP;
    endfunction

endpackage

// File: rtl/cache_cmd_sched_if.sv
// Command, access-operation and sweep handshake bundle of the scheduler.
// master drives commands and accepts work; slave is the scheduler.
interface cache_cmd_sched_if #(
    parameter int SET_BITS = 14
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_code;
    logic [31:0]         cmd_addr;
    logic                op_valid;
    logic                op_ready;
    logic [3:0]          op_code;
    logic [31:0]         op_addr;
    logic                sweep_valid;
    logic                sweep_ready;
    logic                sweep_clear;
    logic [SET_BITS-1:0] sweep_set;

    modport master (
        output cmd_valid, cmd_code, cmd_addr, op_ready, sweep_ready,
        input  cmd_ready, op_valid, op_code, op_addr,
        input  sweep_valid, sweep_clear, sweep_set
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_addr, op_ready, sweep_ready,
        output cmd_ready, op_valid, op_code, op_addr,
        output sweep_valid, sweep_clear, sweep_set
    );
endinterface

// File: rtl/cmd_fifo.sv
// Power-of-two command buffer with registered full/empty flags.
module cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             wr_en, rd_en;

    assign wr_en = push_i && !full_q;
    assign rd_en = pop_i && !empty_q;

    always_comb cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (rd_en) rd_q <= rd_q + AW'(1);
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == CW'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/cache_cmd_sched.sv
// Trace command scheduler: buffers commands, issues accesses in order and
// walks every cache set for clear/print sweeps, ending with a final print.
module cache_cmd_sched
    import cache_sim_pkg::*;
#(
    parameter int SET_BITS   = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    cache_cmd_sched_if.slave    bus,
    input  logic                done,
    output logic                finished,
    output logic [7:0]          bad_cnt
);
    localparam logic [SET_BITS-1:0] LAST_SET = '1;

    sched_state_e        state_q;
    logic                op_valid_q, sw_valid_q, sw_clear_q, fin_q;
    logic [3:0]          op_code_q;
    logic [31:0]         op_addr_q;
    logic [SET_BITS-1:0] set_q;
    logic [7:0]          bad_q;

    logic full, empty, push, pop;
    cmd_t head, wr_cmd;

    assign wr_cmd        = '{code: bus.cmd_code, addr: bus.cmd_addr};
    assign bus.cmd_ready = !full && !fin_q;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state_q == S_IDLE) && !empty;

    cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (wr_cmd),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_valid_q <= 1'b0;
            op_code_q  <= '0;
            op_addr_q  <= '0;
            sw_valid_q <= 1'b0;
            sw_clear_q <= 1'b0;
            set_q      <= '0;
            fin_q      <= 1'b0;
            bad_q      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // buffered work wins over the end-of-trace flag
                    if (!empty) begin
                        unique case (1'b1)
                            is_access(head.code): begin
                                op_valid_q <= 1'b1;
                                op_code_q  <= head.code;
                                op_addr_q  <= head.addr;
                                state_q    <= S_ISSUE;
                            end
                            (head.code == CMD_CLEAR),
                            (head.code == CMD_PRINT): begin
                                sw_valid_q <= 1'b1;
                                sw_clear_q <= head.code == CMD_CLEAR;
                                set_q      <= '0;
                                state_q    <= S_SWEEP;
                            end
                            default: begin
                                if (bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
                            end
                        endcase
                    end else if (done) begin
                        sw_valid_q <= 1'b1;
                        sw_clear_q <= 1'b0;
                        set_q      <= '0;
                        state_q    <= S_FINAL;
                    end
                end
                S_ISSUE: begin
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_SWEEP, S_FINAL: begin
                    if (bus.sweep_ready) begin
                        set_q <= set_q + SET_BITS'(1);
                        if (set_q == LAST_SET) begin
                            sw_valid_q <= 1'b0;
                            if (state_q == S_FINAL) begin
                                fin_q   <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                end
                S_DONE: begin
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.op_valid    = op_valid_q;
    assign bus.op_code     = op_code_q;
    assign bus.op_addr     = op_addr_q;
    assign bus.sweep_valid = sw_valid_q;
    assign bus.sweep_clear = sw_clear_q;
    assign bus.sweep_set   = set_q;
    assign finished        = fin_q;
    assign bad_cnt         = bad_q;
endmodule

// File: tb/tb_cache_cmd_sched.sv
// Randomized bench for cache_cmd_sched: every accepted command is expanded
// into the expected stream of op/sweep handshakes and compared in order.
module tb_cache_cmd_sched;
    import cache_sim_pkg::*;

    localparam int SB    = 3;
    localparam int NSETS = 1 << SB;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       done = 1'b0;
    logic       finished;
    logic [7:0] bad_cnt;

    cache_cmd_sched_if #(.SET_BITS(SB)) bus ();

    cache_cmd_sched #(
        .SET_BITS   (SB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .done     (done),
        .finished (finished),
        .bad_cnt  (bad_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_bad = 0;
    int op_mode = 0;
    int sw_mode = 0;
    logic [39:0] exp_q[$];
    logic [39:0] obs_q[$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] ev_op(logic [3:0] c, logic [31:0] a);
        return {4'h1, c, a};
    endfunction

    function automatic logic [39:0] ev_sw(logic clr, int s);
        return {4'h2, 3'b000, clr, 32'(s)};
    endfunction

    task automatic model_cmd(logic [3:0] c, logic [31:0] a);
        if (c <= 4'd4) exp_q.push_back(ev_op(c, a));
        else if (c == 4'd8 || c == 4'd9)
            for (int s = 0; s < NSETS; s++) exp_q.push_back(ev_sw(c == 4'd8, s));
        else if (exp_bad < 255) exp_bad++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cmd_ready is registered, so its value one step after an edge holds at the next edge
    task automatic send(logic [3:0] c, logic [31:0] a, int bound, output bit ok);
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = c;
        bus.cmd_addr  = a;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            ok = bus.cmd_ready;
            tick();
        end
        bus.cmd_valid = 1'b0;
        if (ok) model_cmd(c, a);
    endtask

    task automatic drain(string tag, int bound);
        int i = 0;
        while (obs_q.size() < exp_q.size() && i < bound) begin
            tick();
            i++;
        end
        repeat (4) tick();
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k < obs_q.size()) chk({tag, "_event"}, obs_q[k], exp_q[k]);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_reset(string t);
        chk({t, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({t, "_op_valid"}, bus.op_valid, 0);
        chk({t, "_sweep_valid"}, bus.sweep_valid, 0);
        chk({t, "_sweep_clear"}, bus.sweep_clear, 0);
        chk({t, "_sweep_set"}, bus.sweep_set, 0);
        chk({t, "_op_code"}, bus.op_code, 0);
        chk({t, "_op_addr"}, bus.op_addr, 0);
        chk({t, "_finished"}, finished, 0);
        chk({t, "_bad_cnt"}, bad_cnt, 0);
    endtask

    initial begin
        bus.op_ready    = 1'b0;
        bus.sweep_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.op_ready    = (op_mode == 2) ? 1'($urandom) : (op_mode == 1);
            bus.sweep_ready = (sw_mode == 2) ? 1'($urandom) : (sw_mode == 1);
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.op_valid || bus.sweep_valid)
                chk("valid_exclusive", bus.op_valid && bus.sweep_valid, 0);
            if (bus.op_valid && bus.op_ready)
                obs_q.push_back(ev_op(bus.op_code, bus.op_addr));
            if (bus.sweep_valid && bus.sweep_ready)
                obs_q.push_back(ev_sw(bus.sweep_clear, int'(bus.sweep_set)));
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit hit;
        bus.cmd_valid = 1'b0;
        bus.cmd_code  = '0;
        bus.cmd_addr  = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // first-access latency
        op_mode = 1;
        tick();
        tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = 4'd0;
        bus.cmd_addr  = 32'h0000_1234;
        chk("lat_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        model_cmd(4'd0, 32'h0000_1234);
        chk("lat_n", bus.op_valid, 0);
        tick();
        chk("lat_n1_valid", bus.op_valid, 1);
        chk("lat_n1_code", bus.op_code, 0);
        chk("lat_n1_addr", bus.op_addr, 32'h0000_1234);
        tick();
        chk("lat_n2_valid", bus.op_valid, 0);
        drain("lat", 20);

        // back-pressure: one op held plus a full buffer
        op_mode = 0;
        tick();
        tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(4'(i % 5), 32'h100 + 32'(i), 3, ok);
            chk("bp_accept", ok, 1);
        end
        chk("bp_full", bus.cmd_ready, 0);
        send(4'd1, 32'hABC, 6, ok);
        chk("bp_blocked", ok, 0);
        chk("bp_no_op", obs_q.size(), 0);
        op_mode = 1;
        send(4'd1, 32'hABC, 20, ok);
        chk("bp_late_accept", ok, 1);
        drain("bp", 100);

        // clear sweep with toggling ready
        sw_mode = 2;
        send(4'd8, 32'h0, 4, ok);
        chk("clr_accept", ok, 1);
        drain("clr", 200);
        chk("clr_idle", bus.sweep_valid, 0);

        // illegal codes dropped
        send(4'd6, 32'h1, 4, ok);
        send(4'd15, 32'h2, 4, ok);
        send(4'd1, 32'h55, 4, ok);
        drain("bad", 50);
        chk("bad_cnt", bad_cnt, 8'(exp_bad));

        // random traffic
        op_mode = 2;
        for (int n = 0; n < 60; n++) begin
            send(4'($urandom_range(0, 15)), $urandom, 200, ok);
            chk("rnd_accept", ok, 1);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain("rnd", 5000);
        chk("rnd_bad_cnt", bad_cnt, 8'(exp_bad));

        // end of trace with work still queued
        op_mode = 0;
        tick();
        tick();
        send(4'd2, 32'h10, 4, ok);
        send(4'd3, 32'h20, 4, ok);
        done = 1'b1;
        for (int s = 0; s < NSETS; s++) exp_q.push_back(ev_sw(1'b0, s));
        op_mode = 2;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            hit = finished;
            if (!hit) tick();
        end
        chk("fin_reached", hit, 1);
        drain("fin", 50);
        chk("fin_cmd_ready", bus.cmd_ready, 0);
        done = 1'b0;
        tick();
        chk("fin_sticky", finished, 1);
        send(4'd0, 32'h1, 5, ok);
        chk("fin_ignore_cmd", ok, 0);
        repeat (4) tick();
        chk("fin_no_op", obs_q.size(), 0);

        // asynchronous reset in the middle of a sweep
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_bad = 0;
        exp_q.delete();
        obs_q.delete();
        tick();
        op_mode = 0;
        sw_mode = 1;
        send(4'd8, 32'h0, 4, ok);
        send(4'd0, 32'h77, 4, ok);
        send(4'd1, 32'h88, 4, ok);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            hit = bus.sweep_valid && (bus.sweep_set == 3);
            if (!hit) tick();
        end
        chk("rst_reach_set3", hit, 1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        obs_q.delete();
        #1;
        check_reset("rst_mid");
        tick();
        tick();
        rst_n = 1'b1;
        op_mode = 1;
        repeat (20) tick();
        chk("rst_flushed", obs_q.size(), 0);
        chk("rst_idle_ready", bus.cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
